// File: rtl/scan_ctl_pkg.sv
// Shared scan-controller definitions: layer codes, field widths, FSM encoding.
package scan_ctl_pkg;

  localparam int unsigned ROW_W   = 9;
  localparam int unsigned COL_W   = 10;
  localparam int unsigned FMAP_W  = 7;
  localparam int unsigned LAYER_W = 4;

  // Codec-wide layer codes; 2..7 are the convolution layers.
  typedef enum logic [LAYER_W-1:0] {
    L_IDLE   = 4'd0,
    L_INPUT  = 4'd1,
    L_CONV1  = 4'd2,
    L_CONV2  = 4'd3,
    L_CONV3  = 4'd4,
    L_CONV4  = 4'd5,
    L_CONV5  = 4'd6,
    L_CONV6  = 4'd7,
    L_FINISH = 4'd8
  } layer_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } scan_fsm_e;

  // Index of the last fmap; a requested count of 0 behaves as 1.
  function automatic logic [FMAP_W-1:0] fmap_last(input logic [FMAP_W-1:0] n);
    return (n == '0) ? '0 : n - FMAP_W'(1);
  endfunction

endpackage

// File: rtl/delay_line.sv
// Parameterised width/depth register shift line with synchronous reset.
module delay_line #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [DEPTH];

  // Shift one stage every cycle; reset clears all stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/scan_ctl.sv
// Layer scan controller: walks row/col over fmap_num feature maps, then drains
// for DLY cycles so the delayed fmap index catches up before done.
// Optional feature: SCAN_STALL_EN adds a stall input that freezes the scan.
module scan_ctl
  import scan_ctl_pkg::*;
#(
  parameter int unsigned ROW_NUM = 360,
  parameter int unsigned COL_NUM = 640,
  parameter int unsigned DLY     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W-1:0] layer,
  input  logic [FMAP_W-1:0]  fmap_num,
`ifdef SCAN_STALL_EN
  input  logic               stall,
`endif
  output logic [ROW_W-1:0]   row,
  output logic [COL_W-1:0]   col,
  output logic [LAYER_W-1:0] state,
  output logic               valid,
  output logic               fmap_end,
  output logic [FMAP_W-1:0]  fmap_idx,
  output logic [FMAP_W-1:0]  fmap_idx_delay4,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = (DLY > 1) ? $clog2(DLY) : 1;

  scan_fsm_e          fsm_q, fsm_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [FMAP_W-1:0]  fidx_q, fidx_d;
  logic [FMAP_W-1:0]  flast_q, flast_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic               hold, adv, row_last, col_last, drain_last;

`ifdef SCAN_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // Status decode from the current registers.
  always_comb begin
    adv        = (fsm_q == S_RUN) && !hold;
    row_last   = (row_q == ROW_W'(ROW_NUM - 1));
    col_last   = (col_q == COL_W'(COL_NUM - 1));
    drain_last = (fsm_q == S_DRAIN) && (dcnt_q == CNT_W'(DLY - 1));
  end

  assign valid    = adv;
  assign fmap_end = adv && row_last && col_last;
  assign done     = drain_last;
  assign busy     = (fsm_q != S_IDLE) && !drain_last;
  assign state    = (fsm_q == S_IDLE) ? LAYER_W'(L_IDLE) : layer_q;
  assign row      = row_q;
  assign col      = col_q;
  assign fmap_idx = fidx_q;

  // Next-state and scan-position logic.
  always_comb begin
    fsm_d   = fsm_q;
    row_d   = row_q;
    col_d   = col_q;
    fidx_d  = fidx_q;
    flast_d = flast_q;
    layer_d = layer_q;
    dcnt_d  = dcnt_q;
    case (fsm_q)
      S_IDLE: begin
        row_d  = '0;
        col_d  = '0;
        fidx_d = '0;
        dcnt_d = '0;
        if (start) begin
          fsm_d   = S_RUN;
          layer_d = layer;
          flast_d = fmap_last(fmap_num);
        end
      end
      S_RUN: begin
        if (adv) begin
          if (!col_last) begin
            col_d = col_q + COL_W'(1);
          end else if (!row_last) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else if (fidx_q != flast_q) begin
            col_d  = '0;
            row_d  = '0;
            fidx_d = fidx_q + FMAP_W'(1);
          end else begin
            // Last pixel of the last fmap: position holds through the drain.
            fsm_d  = S_DRAIN;
            dcnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_last) begin
          fsm_d  = S_IDLE;
          row_d  = '0;
          col_d  = '0;
          fidx_d = '0;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State and position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      fidx_q  <= '0;
      flast_q <= '0;
      layer_q <= '0;
      dcnt_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fidx_q  <= fidx_d;
      flast_q <= flast_d;
      layer_q <= layer_d;
      dcnt_q  <= dcnt_d;
    end
  end

  delay_line #(
    .W     (FMAP_W),
    .DEPTH (DLY)
  ) u_fidx_dly (
    .clk (clk),
    .rst (rst),
    .d   (fidx_q),
    .q   (fmap_idx_delay4)
  );

endmodule

// File: tb/tb_scan_ctl.sv
// Directed bench for scan_ctl with a 2x3 feature map and a 4-deep index delay.
module tb_scan_ctl;

  localparam int R   = 2;
  localparam int C   = 3;
  localparam int PIX = R * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] layer;
  logic [6:0] fmap_num;
`ifdef SCAN_STALL_EN
  logic       stall;
`endif
  logic [8:0] row;
  logic [9:0] col;
  logic [3:0] state;
  logic       valid, fmap_end, busy, done;
  logic [6:0] fmap_idx, fmap_idx_delay4;

  int n_tests = 0;
  int n_fail  = 0;

  logic       mon_en = 1'b0;
  logic [6:0] hist [4];

  always #5 clk = ~clk;

  scan_ctl #(.ROW_NUM(R), .COL_NUM(C), .DLY(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .layer           (layer),
    .fmap_num        (fmap_num),
`ifdef SCAN_STALL_EN
    .stall           (stall),
`endif
    .row             (row),
    .col             (col),
    .state           (state),
    .valid           (valid),
    .fmap_end        (fmap_end),
    .fmap_idx        (fmap_idx),
    .fmap_idx_delay4 (fmap_idx_delay4),
    .busy            (busy),
    .done            (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for the delayed index: the last four pre-edge fmap_idx values.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] = '0;
    end else begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = fmap_idx;
    end
  end

  always @(negedge clk) begin
    if (mon_en) check("dly4", 32'(fmap_idx_delay4), 32'(hist[3]));
  end

  // One full layer scan; r1/r2 are cycles with a stray start, st_* a stall window.
  task automatic run_scan(input logic [3:0] lay, input logic [6:0] fnum, input int nf,
                          input int r1, input int r2, input int st_at, input int st_len,
                          input int exp_end1);
    int   p, last_v, done_c, nd, ne, first_end;
    logic prev_busy;
    p = 0; last_v = -1; done_c = -1; nd = 0; ne = 0; first_end = -1; prev_busy = 1'b0;
    start = 1'b1; layer = lay; fmap_num = fnum;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 200 && done_c < 0; cyc++) begin
      if (cyc == r1 || cyc == r2) begin
        start = 1'b1; layer = 4'd5; fmap_num = 7'd0;
      end else begin
        start = 1'b0;
      end
`ifdef SCAN_STALL_EN
      stall = (cyc >= st_at && cyc < st_at + st_len);
`endif
      #1;
      if (valid) begin
        check("row",   32'(row),      32'((p / C) % R));
        check("col",   32'(col),      32'(p % C));
        check("fidx",  32'(fmap_idx), 32'(p / PIX));
        check("fend",  32'(fmap_end), 32'((p % PIX) == PIX - 1));
        check("state", 32'(state),    32'(lay));
        p++;
        last_v = cyc;
      end else begin
        check("fend_novalid", 32'(fmap_end), 32'(0));
      end
      if (fmap_end) begin
        ne++;
        if (first_end < 0) first_end = cyc;
      end
      if (done) begin
        nd++;
        done_c = cyc;
        check("busy_at_done",     32'(busy),      32'(0));
        check("busy_before_done", 32'(prev_busy), 32'(1));
      end
      prev_busy = busy;
      tick();
    end
    start = 1'b0;
`ifdef SCAN_STALL_EN
    stall = 1'b0;
`endif
    #1;
    check("pixels",      32'(p),         32'(nf * PIX));
    check("done_count",  32'(nd),        32'(1));
    check("fend_count",  32'(ne),        32'(nf));
    check("first_fend",  32'(first_end), 32'(exp_end1));
    check("done_lat",    32'(done_c - last_v), 32'(4));
    check("idle_state",  32'(state),     32'(0));
    check("idle_busy",   32'(busy),      32'(0));
    check("idle_rowcol", 32'({row, col}), 32'(0));
    check("idle_fidx",   32'(fmap_idx),  32'(0));
    check("idle_done",   32'(done),      32'(0));
    tick();
  endtask

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; layer = '0; fmap_num = '0;
`ifdef SCAN_STALL_EN
    stall = 1'b0;
`endif
    tick();
    mon_en = 1'b1;
    tick();
    check("rst_state", 32'(state),    32'(0));
    check("rst_busy",  32'(busy),     32'(0));
    check("rst_valid", 32'(valid),    32'(0));
    check("rst_done",  32'(done),     32'(0));
    check("rst_fend",  32'(fmap_end), 32'(0));
    check("rst_pos",   32'({row, col, fmap_idx}), 32'(0));
    check("rst_dly4",  32'(fmap_idx_delay4), 32'(0));
    rst = 1'b0;
    tick();

    // Two fmaps: ends at cycles 6 and 12, done at 16.
    run_scan(4'd3, 7'd2, 2, -1, -1, -1, 0, 6);
    // fmap_num of 0 scans exactly one fmap.
    run_scan(4'd7, 7'd0, 1, -1, -1, -1, 0, 6);
    // Stray starts during RUN and DRAIN are ignored.
    run_scan(4'd2, 7'd2, 2, 3, 14, -1, 0, 6);
`ifdef SCAN_STALL_EN
    // Stall three cycles on the last pixel of a single fmap.
    run_scan(4'd4, 7'd1, 1, -1, -1, 6, 3, 9);
`endif

    // Mid-scan reset at row 1, col 1 aborts without done.
    start = 1'b1; layer = 4'd6; fmap_num = 7'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_row", 32'(row), 32'(1));
    check("pre_rst_col", 32'(col), 32'(1));
    rst = 1'b1;
    tick();
    check("abort_state", 32'(state), 32'(0));
    check("abort_busy",  32'(busy),  32'(0));
    check("abort_pos",   32'({row, col}), 32'(0));
    check("abort_valid", 32'(valid), 32'(0));
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      tick();
    end
    check("abort_no_done", 32'(nd), 32'(0));
    check("abort_idle",    32'(state), 32'(0));

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
